// File: rtl/vector_gather_collector_pkg.sv
// Shared types for the gather collector: lane data width and the FSM state
// encoding, exported so surrounding logic and benches can decode the state.
`include "defines.sv"
package vector_gather_collector_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    GC_IDLE    = 2'd0,
    GC_COLLECT = 2'd1,
    GC_WRITE   = 2'd2
  } gc_state_t;
endpackage

// File: rtl/defines.sv
// Shared vector-unit sizing macros used across the vector pipeline.
`ifndef DEFINES_SV
`define DEFINES_SV
`define VECTOR_LANES  16
`define VECTOR_BITS   (32 * `VECTOR_LANES)
`define REG_IDX_WIDTH 7
`endif

// File: rtl/vector_gather_collector.sv
// vector_gather_collector: gathers per-lane load results into one vector and
// issues a single masked write on the shared register-file writeback port,
// yielding to the normal writeback stage whenever it is using the port.
// Build option: define GATHER_ERROR_CHECK_EN to enable the sticky gc_error
// flag for stray, unmasked or duplicate lane results.
`include "defines.sv"
module vector_gather_collector
  import vector_gather_collector_pkg::*;
#(
  parameter int  LANES         = `VECTOR_LANES,
  parameter int  REG_IDX_WIDTH = `REG_IDX_WIDTH,
  localparam int IDX_W         = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      gc_start,
  input  logic [REG_IDX_WIDTH-1:0]  gc_reg,
  input  logic [LANES-1:0]          gc_mask,
  input  logic                      gc_abort,
  input  logic                      lane_valid,
  input  logic [IDX_W-1:0]          lane_idx,
  input  logic [DATA_W-1:0]         lane_data,
  input  logic                      wb_port_busy,
  output logic                      gc_busy,
  output logic                      gc_done,
  output logic                      gc_error,
  output logic [REG_IDX_WIDTH-1:0]  wb_writeback_reg,
  output logic [DATA_W*LANES-1:0]   wb_writeback_value,
  output logic [LANES-1:0]          wb_writeback_mask,
  output logic                      wb_enable_vector_writeback
);

  gc_state_t                state, state_nxt;
  logic [LANES-1:0]         mask_q, received, lane_sel, lane_we;
  logic [REG_IDX_WIDTH-1:0] reg_q;
  logic [DATA_W-1:0]        slot_q [LANES];
  logic                     start_ok, zero_start, open_gather;
  logic                     zero_done_q, collect_full;

  // A start only counts from IDLE and loses to a simultaneous abort
  assign start_ok     = (state == GC_IDLE) && gc_start && !gc_abort;
  assign zero_start   = start_ok && (gc_mask == '0);
  assign open_gather  = start_ok && !zero_start;
  assign collect_full = ((received | lane_we) == mask_q);

  // Decode the incoming lane; only expected, not-yet-received lanes are captured
  always_comb begin
    lane_sel           = '0;
    lane_sel[lane_idx] = 1'b1;
    lane_we            = '0;
    if (state == GC_COLLECT && lane_valid && !gc_abort)
      lane_we = lane_sel & mask_q & ~received;
  end

  // Next-state logic; abort wins over every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      GC_IDLE:    if (open_gather)   state_nxt = GC_COLLECT;
      GC_COLLECT: if (collect_full)  state_nxt = GC_WRITE;
      GC_WRITE:   if (!wb_port_busy) state_nxt = GC_IDLE;
      default:                       state_nxt = GC_IDLE;
    endcase
    if (gc_abort)
      state_nxt = GC_IDLE;
  end

  // Control state, destination latch and received-lane tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= GC_IDLE;
      reg_q       <= '0;
      mask_q      <= '0;
      received    <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      zero_done_q <= zero_start;
      if (open_gather) begin
        reg_q    <= gc_reg;
        mask_q   <= gc_mask;
        received <= '0;
      end else begin
        received <= received | lane_we;
      end
    end
  end

  // One register per lane slot, cleared on a new gather, written once per gather
  for (genvar g = 0; g < LANES; g++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!reset)
        slot_q[g] <= '0;
      else if (open_gather)
        slot_q[g] <= '0;
      else if (lane_we[g])
        slot_q[g] <= lane_data;
    end
    assign wb_writeback_value[g*DATA_W +: DATA_W] = slot_q[g];
  end

  assign wb_writeback_reg           = reg_q;
  assign wb_writeback_mask          = mask_q;
  assign wb_enable_vector_writeback = (state == GC_WRITE) && !wb_port_busy && !gc_abort;
  assign gc_done                    = wb_enable_vector_writeback || zero_done_q;
  assign gc_busy                    = (state != GC_IDLE);

`ifdef GATHER_ERROR_CHECK_EN
  logic err_q, lane_bad;
  assign lane_bad = lane_valid &&
                    ((state != GC_COLLECT) || !mask_q[lane_idx] || received[lane_idx]);

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset)
      err_q <= 1'b0;
    else if (lane_bad)
      err_q <= 1'b1;
  end
  assign gc_error = err_q;
`else
  assign gc_error = 1'b0;
`endif

endmodule

// File: tb/tb_vector_gather_collector.sv
// Bench for vector_gather_collector: directed gathers with hand-computed
// expected writes pushed into a scoreboard queue, checked by an independent
// monitor whenever the write strobe is seen.
module tb_vector_gather_collector;
  localparam int LANES = 16;
  localparam int RW    = 7;

  typedef struct packed {
    logic [RW-1:0]       r;
    logic [LANES-1:0]    m;
    logic [32*LANES-1:0] v;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                gc_start, gc_abort, lane_valid, wb_port_busy;
  logic [RW-1:0]       gc_reg;
  logic [LANES-1:0]    gc_mask;
  logic [3:0]          lane_idx;
  logic [31:0]         lane_data;
  logic                gc_busy, gc_done, gc_error, wb_en;
  logic [RW-1:0]       wb_reg;
  logic [32*LANES-1:0] wb_val;
  logic [LANES-1:0]    wb_mask;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_err;

  vector_gather_collector dut (
    .clk(clk), .reset(reset), .gc_start(gc_start), .gc_reg(gc_reg),
    .gc_mask(gc_mask), .gc_abort(gc_abort), .lane_valid(lane_valid),
    .lane_idx(lane_idx), .lane_data(lane_data), .wb_port_busy(wb_port_busy),
    .gc_busy(gc_busy), .gc_done(gc_done), .gc_error(gc_error),
    .wb_writeback_reg(wb_reg), .wb_writeback_value(wb_val),
    .wb_writeback_mask(wb_mask), .wb_enable_vector_writeback(wb_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32*LANES-1:0] act,
                       input logic [32*LANES-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [32*LANES-1:0] put(input logic [32*LANES-1:0] v,
                                              input int lane, input logic [31:0] d);
    logic [32*LANES-1:0] r;
    r = v;
    r[lane*32 +: 32] = d;
    return r;
  endfunction

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d mask %0h expected no write", wb_reg, wb_mask);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wb_reg",   {505'd0, wb_reg}, {505'd0, e.r});
        check("wb_mask",  {496'd0, wb_mask}, {496'd0, e.m});
        check("wb_value", wb_val, e.v);
        check("done_with_write", {511'd0, gc_done}, 512'd1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [RW-1:0] r, input logic [LANES-1:0] m);
    gc_reg = r; gc_mask = m; gc_start = 1'b1;
    cyc();
    gc_start = 1'b0;
  endtask

  task automatic lane(input int i, input logic [31:0] d);
    lane_valid = 1'b1; lane_idx = 4'(i); lane_data = d;
    cyc();
    lane_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; gc_start = 1'b0; gc_abort = 1'b0; lane_valid = 1'b0;
    wb_port_busy = 1'b0; gc_reg = '0; gc_mask = '0; lane_idx = '0; lane_data = '0;
`ifdef GATHER_ERROR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    cyc(); cyc();
    @(negedge clk);
    check("rst_busy",  {511'd0, gc_busy}, 512'd0);
    check("rst_done",  {511'd0, gc_done}, 512'd0);
    check("rst_error", {511'd0, gc_error}, 512'd0);
    check("rst_en",    {511'd0, wb_en}, 512'd0);
    check("rst_reg",   {505'd0, wb_reg}, 512'd0);
    check("rst_mask",  {496'd0, wb_mask}, 512'd0);
    check("rst_value", wb_val, 512'd0);
    reset = 1'b1;
    cyc();

    // Full 16-lane gather, lanes 15..0, one per cycle
    e.r = 7'd5; e.m = 16'hFFFF; e.v = '0;
    for (int i = 0; i < LANES; i++) e.v = put(e.v, i, 32'h100 + i);
    q.push_back(e);
    start(7'd5, 16'hFFFF);
    for (int i = LANES - 1; i >= 1; i--) lane(i, 32'h100 + i);
    @(negedge clk);
    check("t1_no_early_write", {511'd0, wb_en}, 512'd0);
    check("t1_busy", {511'd0, gc_busy}, 512'd1);
    #1;
    lane(0, 32'h100);
    @(negedge clk);
    check("t1_write_now", {511'd0, wb_en}, 512'd1);
    cyc();
    check("t1_idle_after", {511'd0, gc_busy}, 512'd0);

    // Sparse mask, lanes out of order
    e.r = 7'd3; e.m = 16'h0005; e.v = put(put('0, 2, 32'hAA), 0, 32'hBB);
    q.push_back(e);
    start(7'd3, 16'h0005);
    lane(2, 32'hAA);
    lane(0, 32'hBB);
    cyc();

    // Writeback port busy for three WRITE cycles
    e.r = 7'd12; e.m = 16'h0010; e.v = put('0, 4, 32'hDEADBEEF);
    q.push_back(e);
    start(7'd12, 16'h0010);
    wb_port_busy = 1'b1;
    lane(4, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_en",    {511'd0, wb_en}, 512'd0);
      check("stall_done",  {511'd0, gc_done}, 512'd0);
      check("stall_busy",  {511'd0, gc_busy}, 512'd1);
      check("stall_reg",   {505'd0, wb_reg}, {505'd0, e.r});
      check("stall_mask",  {496'd0, wb_mask}, {496'd0, e.m});
      check("stall_value", wb_val, e.v);
      cyc();
    end
    wb_port_busy = 1'b0;
    @(negedge clk);
    check("stall_release_en", {511'd0, wb_en}, 512'd1);
    cyc();

    // Abort after 8 of 16 lanes (with a lane in the abort cycle), then a new gather
    start(7'd7, 16'hFFFF);
    for (int i = 0; i < 8; i++) lane(i, 32'h700 + i);
    gc_abort = 1'b1; lane_valid = 1'b1; lane_idx = 4'd8; lane_data = 32'h708;
    cyc();
    gc_abort = 1'b0; lane_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", {511'd0, gc_busy}, 512'd0);
    check("abort_no_done", {511'd0, gc_done}, 512'd0);
    #1;
    gc_abort = 1'b1;
    start(7'd1, 16'h0001);
    gc_abort = 1'b0;
    check("abort_beats_start", {511'd0, gc_busy}, 512'd0);
    e.r = 7'd9; e.m = 16'h0001; e.v = put('0, 0, 32'h99);
    q.push_back(e);
    start(7'd9, 16'h0001);
    lane(0, 32'h99);
    cyc();

    // Empty mask: done next cycle, no write
    start(7'd4, 16'h0000);
    @(negedge clk);
    check("zero_done",  {511'd0, gc_done}, 512'd1);
    check("zero_no_en", {511'd0, wb_en}, 512'd0);
    check("zero_idle",  {511'd0, gc_busy}, 512'd0);
    cyc();
    check("zero_done_pulse", {511'd0, gc_done}, 512'd0);

    // Duplicate lane 3: first data kept, error only in the checking build
    check("pre_dup_error", {511'd0, gc_error}, 512'd0);
    e.r = 7'd2; e.m = 16'h0018; e.v = put(put('0, 3, 32'h33), 4, 32'h55);
    q.push_back(e);
    start(7'd2, 16'h0018);
    lane(3, 32'h33);
    lane(3, 32'h44);
    @(negedge clk);
    check("dup_error", {511'd0, gc_error}, {511'd0, exp_err});
    #1;
    lane(4, 32'h55);
    cyc();

    // Reset in the middle of a gather
    start(7'd1, 16'h00FF);
    lane(0, 32'h11);
    lane(1, 32'h22);
    reset = 1'b0;
    cyc();
    @(negedge clk);
    check("mid_rst_busy",  {511'd0, gc_busy}, 512'd0);
    check("mid_rst_en",    {511'd0, wb_en}, 512'd0);
    check("mid_rst_reg",   {505'd0, wb_reg}, 512'd0);
    check("mid_rst_mask",  {496'd0, wb_mask}, 512'd0);
    check("mid_rst_value", wb_val, 512'd0);
    check("mid_rst_error", {511'd0, gc_error}, 512'd0);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    check("all_writes_seen", 512'(q.size()), 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
